// File: rtl/demux8_scatter_if.sv
// Stream-in / bank-out bundle for the 1:8 scatter buffer.
// The slave view belongs to the buffer and the master view to its environment.
interface demux8_scatter_if #(
  parameter int DATA_W = 32,
  parameter int LANES  = 8
);
  logic                    enable;
  logic                    flush;
  logic                    in_valid;
  logic                    in_ready;
  logic [DATA_W-1:0]       in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [LANES*DATA_W-1:0] dout;
  logic [2:0]              fill_cnt;

  modport slave (
    input  enable, flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, dout, fill_cnt
  );

  modport master (
    output enable, flush, in_valid, in_data, out_ready,
    input  in_ready, out_valid, dout, fill_cnt
  );
endinterface

// File: rtl/demux8_scatter.sv
// Serial-to-parallel 1:8 scatter buffer: packs 8 consecutive input words into one
// parallel bank, filling the next group in a shadow while the previous bank is held.
//
//   state        | meaning
//   FILL0..FILL7 | fill_q = number of words parked in the shadow for the current group
//   EMPTY        | full_q = 0, no bank presented on dout
//   FULL         | full_q = 1, dout holds a complete bank awaiting out_ready
module demux8_scatter #(
  parameter int DATA_W = 32,
  parameter int LANES  = 8
) (
  input  logic              CLK,
  input  logic              RESETn,
  demux8_scatter_if.slave   bus
);

  localparam logic [2:0] LAST = 3'(LANES - 1);

  logic [2:0]              fill_q, fill_d;
  logic                    full_q, full_d;
  logic [DATA_W-1:0]       shadow [LANES-1];
  logic [LANES*DATA_W-1:0] dout_q;
  logic [LANES*DATA_W-1:0] bank_d;
  logic                    in_ready;
  logic                    accept;
  logic                    load;
  logic                    consume;

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      fill_q <= '0;
      full_q <= 1'b0;
    end else begin
      fill_q <= fill_d;
      full_q <= full_d;
    end
  end

  always_comb begin
    fill_d = fill_q;
    full_d = full_q;
    if (bus.flush)
      fill_d = '0;
    else if (accept)
      fill_d = (fill_q == LAST) ? 3'd0 : fill_q + 3'd1;
    // A bank load wins over a consume so back-to-back banks never bubble.
    if (load)
      full_d = 1'b1;
    else if (consume)
      full_d = 1'b0;
  end

  always_comb begin
    // Only the closing word of a group has to wait for the output bank to drain.
    in_ready = RESETn & bus.enable & ~bus.flush
             & ~((fill_q == LAST) & full_q & ~bus.out_ready);
    accept   = bus.in_valid & in_ready;
    load     = accept & (fill_q == LAST);
    consume  = full_q & bus.out_ready;
  end

  always_comb begin
    bank_d = '0;
    for (int k = 0; k < LANES - 1; k++)
      bank_d[k*DATA_W +: DATA_W] = shadow[k];
    bank_d[(LANES-1)*DATA_W +: DATA_W] = bus.in_data;
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      for (int k = 0; k < LANES - 1; k++)
        shadow[k] <= '0;
      dout_q <= '0;
    end else begin
      if (accept && (fill_q != LAST))
        shadow[fill_q] <= bus.in_data;
      if (load)
        dout_q <= bank_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = full_q;
  assign bus.dout      = dout_q;
  assign bus.fill_cnt  = fill_q;

endmodule

// File: tb/tb_demux8_scatter.sv
// Bench for the 1:8 scatter buffer: directed scenarios plus a long random run, all
// checked against a queue-based model of groups of eight accepted words.
module tb_demux8_scatter;
  localparam int DW = 32;
  localparam int NL = 8;

  logic CLK    = 1'b0;
  logic RESETn = 1'b0;
  int   errors = 0;
  int   checks = 0;

  demux8_scatter_if #(.DATA_W(DW), .LANES(NL)) bus ();
  demux8_scatter #(.DATA_W(DW), .LANES(NL)) dut (.CLK(CLK), .RESETn(RESETn), .bus(bus));

  always #5 CLK = ~CLK;

  // Model: words of the partial group, whether a bank is held, and the last bank emitted.
  logic [DW-1:0] part [$];
  bit            held;
  logic [DW-1:0] mbank [NL];

  function automatic logic [NL*DW-1:0] exp_dout();
    logic [NL*DW-1:0] v;
    for (int k = 0; k < NL; k++) v[k*DW +: DW] = mbank[k];
    return v;
  endfunction

  function automatic logic [NL*DW-1:0] seq_bank(input int base);
    logic [NL*DW-1:0] v;
    for (int k = 0; k < NL; k++) v[k*DW +: DW] = DW'(base + k);
    return v;
  endfunction

  function automatic bit model_ready();
    return RESETn && bus.enable && !bus.flush &&
           !(part.size() == NL - 1 && held && !bus.out_ready);
  endfunction

  task automatic model_clear();
    part.delete();
    held = 1'b0;
    for (int k = 0; k < NL; k++) mbank[k] = '0;
  endtask

  task automatic tick();
    bit acc;
    bit loaded;
    #1;
    acc    = bus.in_valid && model_ready();
    loaded = 1'b0;
    @(posedge CLK);
    if (bus.flush) part.delete();
    else if (acc) begin
      if (part.size() == NL - 1) begin
        for (int k = 0; k < NL - 1; k++) mbank[k] = part[k];
        mbank[NL-1] = bus.in_data;
        part.delete();
        held   = 1'b1;
        loaded = 1'b1;
      end else part.push_back(bus.in_data);
    end
    if (!loaded && held && bus.out_ready) held = 1'b0;
    #2;
  endtask

  task automatic push(input int w);
    bus.in_valid = 1'b1;
    bus.in_data  = DW'(w);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic do_reset();
    bus.enable = 1'b1; bus.flush = 1'b0; bus.in_valid = 1'b0;
    bus.in_data = '0;  bus.out_ready = 1'b0;
    RESETn = 1'b0;
    model_clear();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RESETn = 1'b1;
  endtask

  task automatic test_reset();
    bus.enable = 1'b1; bus.flush = 1'b0; bus.in_valid = 1'b1;
    bus.in_data = 32'hdead_beef; bus.out_ready = 1'b1;
    RESETn = 1'b0;
    model_clear();
    #3;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", bus.in_ready); end
    repeat (2) @(posedge CLK);
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.fill_cnt !== 3'd0) begin errors++; $display("FAIL reset_fill_cnt: got %0d expected 0", bus.fill_cnt); end
    checks++; if (bus.dout !== '0) begin errors++; $display("FAIL reset_dout: got %h expected 0", bus.dout); end
    bus.in_valid = 1'b0;
    @(negedge CLK);
    RESETn = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b expected 1", bus.in_ready); end
  endtask

  task automatic test_basic();
    int vcycles;
    do_reset();
    bus.out_ready = 1'b1;
    for (int i = 10; i < 17; i++) push(i);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.fill_cnt !== 3'd7) begin errors++; $display("FAIL basic_fill7: got %0d expected 7", bus.fill_cnt); end
    push(17);
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b expected 1", bus.out_valid); end
    checks++; if (bus.dout !== seq_bank(10)) begin errors++; $display("FAIL basic_dout: got %h expected %h", bus.dout, seq_bank(10)); end
    checks++; if (bus.fill_cnt !== 3'd0) begin errors++; $display("FAIL basic_fill_wrap: got %0d expected 0", bus.fill_cnt); end
    vcycles = 1;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (bus.out_valid === 1'b1) vcycles++;
    end
    checks++; if (vcycles != 1) begin errors++; $display("FAIL basic_valid_len: got %0d cycles expected 1", vcycles); end
    checks++; if (bus.dout !== seq_bank(10)) begin errors++; $display("FAIL basic_dout_hold: got %h expected %h", bus.dout, seq_bank(10)); end
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.out_ready = 1'b0;
    for (int i = 10; i < 18; i++) push(i);
    for (int i = 20; i < 27; i++) push(i);
    checks++; if (bus.fill_cnt !== 3'd7) begin errors++; $display("FAIL bp_fill7: got %0d expected 7", bus.fill_cnt); end
    bus.in_valid = 1'b1; bus.in_data = 27;
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_stall_ready: got %b expected 0", bus.in_ready); end
    tick();
    checks++; if (bus.fill_cnt !== 3'd7) begin errors++; $display("FAIL bp_fill_held: got %0d expected 7", bus.fill_cnt); end
    checks++; if (bus.dout !== seq_bank(10)) begin errors++; $display("FAIL bp_dout_held: got %h expected %h", bus.dout, seq_bank(10)); end
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_held: got %b expected 1", bus.out_valid); end
    bus.out_ready = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b expected 1", bus.in_ready); end
    tick();
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_no_bubble: got %b expected 1", bus.out_valid); end
    checks++; if (bus.dout !== seq_bank(20)) begin errors++; $display("FAIL bp_dout_next: got %h expected %h", bus.dout, seq_bank(20)); end
    checks++; if (bus.fill_cnt !== 3'd0) begin errors++; $display("FAIL bp_fill_wrap: got %0d expected 0", bus.fill_cnt); end
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b expected 0", bus.out_valid); end
  endtask

  task automatic test_enable_pause();
    do_reset();
    bus.out_ready = 1'b1;
    for (int i = 10; i < 13; i++) push(i);
    bus.enable = 1'b0; bus.in_valid = 1'b1; bus.in_data = 13;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL en_ready_c%0d: got %b expected 0", c, bus.in_ready); end
      tick();
      checks++; if (bus.fill_cnt !== 3'd3) begin errors++; $display("FAIL en_fill_c%0d: got %0d expected 3", c, bus.fill_cnt); end
    end
    bus.enable = 1'b1;
    for (int i = 13; i < 18; i++) push(i);
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL en_valid: got %b expected 1", bus.out_valid); end
    checks++; if (bus.dout !== seq_bank(10)) begin errors++; $display("FAIL en_dout: got %h expected %h", bus.dout, seq_bank(10)); end
  endtask

  task automatic test_flush();
    do_reset();
    bus.out_ready = 1'b0;
    for (int i = 50; i < 58; i++) push(i);
    for (int i = 10; i < 13; i++) push(i);
    bus.flush = 1'b1; bus.in_valid = 1'b1; bus.in_data = 99;
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL flush_ready: got %b expected 0", bus.in_ready); end
    tick();
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    checks++; if (bus.fill_cnt !== 3'd0) begin errors++; $display("FAIL flush_fill: got %0d expected 0", bus.fill_cnt); end
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL flush_valid_kept: got %b expected 1", bus.out_valid); end
    checks++; if (bus.dout !== seq_bank(50)) begin errors++; $display("FAIL flush_dout_kept: got %h expected %h", bus.dout, seq_bank(50)); end
    bus.out_ready = 1'b1;
    for (int i = 30; i < 38; i++) push(i);
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL flush_new_valid: got %b expected 1", bus.out_valid); end
    checks++; if (bus.dout !== seq_bank(30)) begin errors++; $display("FAIL flush_new_dout: got %h expected %h", bus.dout, seq_bank(30)); end
  endtask

  task automatic test_reset_midop();
    do_reset();
    bus.out_ready = 1'b0;
    for (int i = 60; i < 68; i++) push(i);
    for (int i = 70; i < 75; i++) push(i);
    checks++; if (bus.fill_cnt !== 3'd5 || bus.out_valid !== 1'b1) begin errors++; $display("FAIL midop_setup: got fill=%0d valid=%b expected fill=5 valid=1", bus.fill_cnt, bus.out_valid); end
    #1;
    RESETn = 1'b0;
    model_clear();
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL midop_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.fill_cnt !== 3'd0) begin errors++; $display("FAIL midop_fill: got %0d expected 0", bus.fill_cnt); end
    checks++; if (bus.dout !== '0) begin errors++; $display("FAIL midop_dout: got %h expected 0", bus.dout); end
    @(posedge CLK);
    @(negedge CLK);
    RESETn = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 40; i < 48; i++) push(i);
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL midop_next_valid: got %b expected 1", bus.out_valid); end
    checks++; if (bus.dout !== seq_bank(40)) begin errors++; $display("FAIL midop_next_dout: got %h expected %h", bus.dout, seq_bank(40)); end
  endtask

  task automatic test_random();
    bit took;
    int banks;
    int errs_before;
    do_reset();
    took  = 1'b1;
    banks = 0;
    for (int c = 0; c < 2000; c++) begin
      errs_before   = errors;
      bus.enable    = ($urandom_range(0, 9) != 0);
      bus.flush     = ($urandom_range(0, 39) == 0);
      bus.out_ready = 1'($urandom_range(0, 1));
      if (!bus.in_valid || took) begin
        bus.in_valid = ($urandom_range(0, 3) != 0);
        bus.in_data  = $urandom;
      end
      #1;
      checks++; if (bus.in_ready !== model_ready()) begin errors++; $display("FAIL rand_ready c%0d: got %b expected %b", c, bus.in_ready, model_ready()); end
      took = bus.in_valid && model_ready();
      if (took && part.size() == NL - 1) banks++;
      tick();
      checks++; if (bus.out_valid !== held) begin errors++; $display("FAIL rand_valid c%0d: got %b expected %b", c, bus.out_valid, held); end
      checks++; if (bus.fill_cnt !== 3'(part.size())) begin errors++; $display("FAIL rand_fill c%0d: got %0d expected %0d", c, bus.fill_cnt, part.size()); end
      checks++; if (bus.dout !== exp_dout()) begin errors++; $display("FAIL rand_dout c%0d: got %h expected %h", c, bus.dout, exp_dout()); end
      if (errors - errs_before > 0 && errors > 20) break;
    end
    checks++; if (banks < 20) begin errors++; $display("FAIL rand_activity: got %0d banks expected at least 20", banks); end
    bus.in_valid = 1'b0; bus.flush = 1'b0;
  endtask

  initial begin
    bus.enable = 1'b1; bus.flush = 1'b0; bus.in_valid = 1'b0;
    bus.in_data = '0;  bus.out_ready = 1'b0;
    model_clear();
    test_reset();
    test_basic();
    test_backpressure();
    test_enable_pause();
    test_flush();
    test_reset_midop();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
